spi_bridge: RTL and testbench

SPI_BRIDGE -- requirements
Module: spi_bridge

---
 rtl/spi_bridge.sv | 151 +++++++++++++++
 tb/tb_spi_bridge.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bridge.sv
// Byte-stream to SPI master bridge: command bytes select/deselect chip selects and run N-byte transfers.
// Optional build macro SPI_LOOPBACK_EN feeds mosi_o back into the receive sampler instead of miso_i.
module spi_bridge #(
  parameter int NUM_CS    = 1,
  parameter int CLK_DIV   = 1,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        out_data_i,
  input  logic              out_valid_i,
  output logic              out_ready_o,
  output logic [7:0]        in_data_o,
  output logic              in_valid_o,
  input  logic              in_ready_i,
  output logic              sck_o,
  output logic [NUM_CS-1:0] csn_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {CMD, DATA, SHIFT, RESP} state_t;

  state_t      state_q, state_d;
  logic        rdy_en_q;
  logic [6:0]  cnt_q;
  logic [3:0]  ph_q;
  logic [7:0]  hcnt_q;
  logic [7:0]  tx_q;
  logic [7:0]  rx_q;
  logic        sample;
  logic        out_fire;
  logic        in_fire;
  logic        half_end;

  function automatic logic first_bit(input logic [7:0] b);
    return MSB_FIRST ? b[7] : b[0];
  endfunction

  function automatic logic [7:0] shift_tx(input logic [7:0] b);
    return MSB_FIRST ? {b[6:0], 1'b0} : {1'b0, b[7:1]};
  endfunction

  function automatic logic [7:0] shift_rx(input logic [7:0] r, input logic s);
    return MSB_FIRST ? {r[6:0], s} : {s, r[7:1]};
  endfunction

`ifdef SPI_LOOPBACK_EN
  assign sample = mosi_o;
`else
  assign sample = miso_i;
`endif

  assign out_fire = out_valid_i & out_ready_o;
  assign in_fire  = in_valid_o & in_ready_i;
  assign half_end = (hcnt_q == 8'(CLK_DIV - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= CMD;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_ready_o = rdy_en_q && (state_q == CMD || state_q == DATA);
    in_valid_o  = (state_q == RESP);
    busy_o      = (state_q != CMD);
    case (state_q)
      CMD:   if (out_fire && out_data_i[7:6] == 2'b01) state_d = DATA;
      DATA:  if (out_fire) state_d = SHIFT;
      SHIFT: if (half_end && ph_q == 4'd15) state_d = RESP;
      RESP:  if (in_fire) state_d = (cnt_q != 7'd0) ? DATA : CMD;
      default: state_d = CMD;
    endcase
  end

  // Command decode, byte load and the 16 half-period shift engine
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csn_o     <= '1;
      cnt_q     <= 7'd0;
      ph_q      <= 4'd0;
      hcnt_q    <= 8'd0;
      tx_q      <= 8'd0;
      rx_q      <= 8'd0;
      mosi_o    <= 1'b0;
      sck_o     <= CPOL;
      in_data_o <= 8'd0;
    end else begin
      case (state_q)
        CMD: begin
          if (out_fire) begin
            case (out_data_i[7:6])
              2'b01: cnt_q <= {1'b0, out_data_i[5:0]} + 7'd1;
              2'b10: begin
                if (32'(out_data_i[2:0]) < NUM_CS)
                  csn_o <= ~(NUM_CS'(1) << out_data_i[2:0]);
                else
                  csn_o <= '1;
              end
              2'b11: csn_o <= '1;
              default: ;
            endcase
          end
        end
        DATA: begin
          if (out_fire) begin
            cnt_q  <= cnt_q - 7'd1;
            tx_q   <= out_data_i;
            mosi_o <= first_bit(out_data_i);
            ph_q   <= 4'd0;
            hcnt_q <= 8'd0;
            // With CPHA=1 the leading edge happens as the byte is loaded.
            sck_o  <= CPHA ? ~CPOL : CPOL;
          end
        end
        SHIFT: begin
          if (half_end) begin
            hcnt_q <= 8'd0;
            if (ph_q == 4'd15) begin
              sck_o     <= CPOL;
              in_data_o <= rx_q;
            end else begin
              ph_q  <= ph_q + 4'd1;
              sck_o <= ~sck_o;
              // Sampling ends even half-periods; mosi advances at the end of odd ones.
              if (!ph_q[0]) begin
                rx_q <= shift_rx(rx_q, sample);
              end else begin
                tx_q   <= shift_tx(tx_q);
                mosi_o <= first_bit(shift_tx(tx_q));
              end
            end
          end else begin
            hcnt_q <= hcnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bridge.sv
// Directed bench for spi_bridge: instance A (NUM_CS=4, CLK_DIV=2, mode 0, MSB first)
// and instance B (CPOL=1, CPHA=1, LSB first, CLK_DIV=1).
module tb_spi_bridge;

`ifdef SPI_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] a_out_data, a_in_data;
  logic       a_out_valid, a_out_ready, a_in_valid, a_in_ready;
  logic       a_sck, a_mosi, a_miso, a_busy;
  logic [3:0] a_csn;

  logic [7:0] b_out_data, b_in_data;
  logic       b_out_valid, b_out_ready, b_in_valid, b_in_ready;
  logic       b_sck, b_mosi, b_miso, b_busy;
  logic [0:0] b_csn;

  spi_bridge #(.NUM_CS(4), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .out_data_i(a_out_data), .out_valid_i(a_out_valid), .out_ready_o(a_out_ready),
    .in_data_o(a_in_data), .in_valid_o(a_in_valid), .in_ready_i(a_in_ready),
    .sck_o(a_sck), .csn_o(a_csn), .mosi_o(a_mosi), .miso_i(a_miso), .busy_o(a_busy)
  );

  spi_bridge #(.NUM_CS(1), .CLK_DIV(1), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .out_data_i(b_out_data), .out_valid_i(b_out_valid), .out_ready_o(b_out_ready),
    .in_data_o(b_in_data), .in_valid_o(b_in_valid), .in_ready_i(b_in_ready),
    .sck_o(b_sck), .csn_o(b_csn), .mosi_o(b_mosi), .miso_i(b_miso), .busy_o(b_busy)
  );

  int checks = 0;
  int errors = 0;

  // Slave model for A: mode 0, MSB first, next bit presented after each falling sck edge.
  logic [7:0] a_slv;
  int         a_fbase;
  int         a_fall = 0;
  int         a_rise = 0;
  logic [7:0] a_cap = 8'd0;
  always @(negedge a_sck) a_fall <= a_fall + 1;
  always @(posedge a_sck) begin
    a_rise <= a_rise + 1;
    a_cap  <= {a_cap[6:0], a_mosi};
  end
  assign a_miso = a_slv[3'(7 - (a_fall - a_fbase))];

  // B monitor: capture LSB-first on rising sck, flag any mosi change not on a falling sck edge.
  int         b_rise = 0;
  logic [7:0] b_cap = 8'd0;
  int         b_bad = 0;
  logic       b_prev_sck, b_prev_mosi;
  assign b_miso = 1'b0;
  always @(posedge b_sck) begin
    b_rise <= b_rise + 1;
    b_cap  <= {b_mosi, b_cap[7:1]};
  end
  always @(negedge clk) begin
    b_prev_sck  <= b_sck;
    b_prev_mosi <= b_mosi;
    if (rst === 1'b0 && b_mosi !== b_prev_mosi && !(b_prev_sck === 1'b1 && b_sck === 1'b0))
      b_bad <= b_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] b);
    int n;
    a_out_data  = b;
    a_out_valid = 1'b1;
    n = 0;
    while (!a_out_ready && n < 200) begin
      step();
      n++;
    end
    check("a_send_ready", 32'(a_out_ready), 32'd1);
    step();
    a_out_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    int n;
    b_out_data  = b;
    b_out_valid = 1'b1;
    n = 0;
    while (!b_out_ready && n < 200) begin
      step();
      n++;
    end
    check("b_send_ready", 32'(b_out_ready), 32'd1);
    step();
    b_out_valid = 1'b0;
  endtask

  task automatic wait_valid_a(output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!a_in_valid && k < 500);
  endtask

  task automatic wait_valid_b(output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!b_in_valid && k < 500);
  endtask

  task automatic accept_a();
    a_in_ready = 1'b1;
    step();
    a_in_ready = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_ready"}, 32'(a_out_ready), 32'd0);
    check({tag, "_sck"},   32'(a_sck),       32'd0);
    check({tag, "_csn"},   32'(a_csn),       32'hF);
    check({tag, "_mosi"},  32'(a_mosi),      32'd0);
    check({tag, "_vld"},   32'(a_in_valid),  32'd0);
    check({tag, "_data"},  32'(a_in_data),   32'd0);
    check({tag, "_busy"},  32'(a_busy),      32'd0);
  endtask

  logic [7:0] pay  [3] = '{8'h11, 8'h22, 8'h33};
  logic [7:0] resp [3] = '{8'hC1, 8'h5E, 8'h07};

  initial begin
    int k;
    int r;
    rst = 1'b1;
    a_out_data = 8'd0; a_out_valid = 1'b0; a_in_ready = 1'b0;
    b_out_data = 8'd0; b_out_valid = 1'b0; b_in_ready = 1'b0;
    a_slv = 8'd0; a_fbase = 0;
    repeat (3) step();
    check_reset_a("rst0");
    check("rst0_b_sck", 32'(b_sck), 32'd1);
    rst = 1'b0;
    check("rel_ready_low", 32'(a_out_ready), 32'd0);
    step();
    check("rel_ready_high", 32'(a_out_ready), 32'd1);

    // Chip select handling
    send_a(8'h82);
    check("sel2_csn", 32'(a_csn), 32'hB);
    check("sel2_busy", 32'(a_busy), 32'd0);
    send_a(8'hC0);
    check("desel_csn", 32'(a_csn), 32'hF);
    send_a(8'h85);
    check("sel_oob_csn", 32'(a_csn), 32'hF);

    // Single byte transfer, mode 0, CLK_DIV=2
    send_a(8'h80);
    check("sel0_csn", 32'(a_csn), 32'hE);
    a_slv = 8'h3C;
    a_fbase = a_fall;
    send_a(8'h40);
    check("xfer_busy", 32'(a_busy), 32'd1);
    check("data_ready", 32'(a_out_ready), 32'd1);
    r = a_rise;
    send_a(8'hA5);
    check("shift_ready", 32'(a_out_ready), 32'd0);
    wait_valid_a(k);
    check("lat32", 32'(k), 32'd32);
    check("rises8", 32'(a_rise - r), 32'd8);
    check("mosi_A5", 32'(a_cap), 32'hA5);
    check("rx_3C", 32'(a_in_data), LB ? 32'hA5 : 32'h3C);
    check("sck_idle_resp", 32'(a_sck), 32'd0);
    repeat (3) step();
    check("resp_hold_vld", 32'(a_in_valid), 32'd1);
    check("resp_ready_low", 32'(a_out_ready), 32'd0);
    accept_a();
    check("after_one_busy", 32'(a_busy), 32'd0);
    check("after_one_vld", 32'(a_in_valid), 32'd0);

    // Three-byte transfer with stalled responses
    send_a(8'h42);
    for (int i = 0; i < 3; i++) begin
      a_slv = resp[i];
      a_fbase = a_fall;
      send_a(pay[i]);
      wait_valid_a(k);
      check("multi_lat", 32'(k), 32'd32);
      r = a_rise;
      repeat (10) step();
      check("multi_frozen", 32'(a_rise - r), 32'd0);
      check("multi_sck", 32'(a_sck), 32'd0);
      check("multi_vld", 32'(a_in_valid), 32'd1);
      check("multi_data", 32'(a_in_data), LB ? 32'(pay[i]) : 32'(resp[i]));
      accept_a();
      check("multi_busy", 32'(a_busy), (i < 2) ? 32'd1 : 32'd0);
    end

    // Instance B: CPOL=1, CPHA=1, LSB first
    check("b_idle_sck", 32'(b_sck), 32'd1);
    r = b_rise;
    send_b(8'h40);
    send_b(8'h01);
    check("b_lead_sck", 32'(b_sck), 32'd0);
    check("b_first_mosi", 32'(b_mosi), 32'd1);
    wait_valid_b(k);
    check("b_lat16", 32'(k), 32'd16);
    check("b_rises8", 32'(b_rise - r), 32'd8);
    check("b_mosi_01", 32'(b_cap), 32'h01);
    check("b_sck_end", 32'(b_sck), 32'd1);
    check("b_rx", 32'(b_in_data), LB ? 32'h01 : 32'h00);
    check("b_edge_rule", 32'(b_bad), 32'd0);
    b_in_ready = 1'b1;
    step();
    b_in_ready = 1'b0;
    check("b_busy_end", 32'(b_busy), 32'd0);

    // Reset in the middle of a byte
    send_a(8'h40);
    send_a(8'h5A);
    repeat (14) step();
    check("mid_sck", 32'(a_sck), 32'd1);
    check("mid_mosi", 32'(a_mosi), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_a("rst1");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst1_rel_low", 32'(a_out_ready), 32'd0);
    step();
    check("rst1_rel_high", 32'(a_out_ready), 32'd1);
    send_a(8'h00);
    check("nop_busy", 32'(a_busy), 32'd0);
    check("nop_csn", 32'(a_csn), 32'hF);
    check("nop_ready", 32'(a_out_ready), 32'd1);
    repeat (40) step();
    check("nop_no_resp", 32'(a_in_valid), 32'd0);
    check("nop_sck", 32'(a_sck), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
